// File: rtl/leaf_run_distributor.sv
// Cuts a presorted stream into RUN_LEN-item runs, each closed by a zero terminator,
// dealt round-robin to leaf FIFOs. Define LEAF_DIST_ZERO_GUARD_EN to remap zero items to 1.
module leaf_run_distributor #(
  parameter int unsigned N_LEAVES = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RUN_LEN  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_valid,
  input  logic                i_last,
  output logic                o_ready,
  input  logic [N_LEAVES-1:0] i_fifo_full,
  output logic [DATA_W-1:0]   o_fifo_item,
  output logic [N_LEAVES-1:0] o_fifo_write,
  output logic                o_done
`ifdef LEAF_DIST_ZERO_GUARD_EN
  ,
  output logic                o_zero_seen
`endif
);

  localparam int unsigned CW = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam int unsigned LW = $clog2(N_LEAVES);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_TERM  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [LW-1:0]       leaf_q, leaf_d;
  logic [CW-1:0]       count_q, count_d;
  logic                last_seen_q, last_seen_d;
  logic [N_LEAVES-1:0] write_q, write_d;
  logic [DATA_W-1:0]   item_q, item_d;

  logic                leaf_full;
  logic [LW-1:0]       leaf_nxt;
  logic                xfer;
  logic [DATA_W-1:0]   item_in;

  assign leaf_full = i_fifo_full[leaf_q];
  assign leaf_nxt  = (leaf_q == LW'(N_LEAVES - 1)) ? '0 : leaf_q + 1'b1;
  assign o_ready   = (state_q == S_FILL) && !leaf_full;
  assign xfer      = i_valid && o_ready;

`ifdef LEAF_DIST_ZERO_GUARD_EN
  logic zero_seen_q;

  assign item_in     = (i_data == '0) ? DATA_W'(1) : i_data;
  assign o_zero_seen = zero_seen_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      zero_seen_q <= 1'b0;
    end else if (xfer && (i_data == '0)) begin
      zero_seen_q <= 1'b1;
    end
  end
`else
  assign item_in = i_data;
`endif

  always_comb begin
    state_d     = state_q;
    leaf_d      = leaf_q;
    count_d     = count_q;
    last_seen_d = last_seen_q;
    write_d     = '0;
    item_d      = item_q;
    case (state_q)
      S_FILL: begin
        if (xfer) begin
          write_d[leaf_q] = 1'b1;
          item_d          = item_in;
          if ((count_q == CW'(RUN_LEN - 1)) || i_last) begin
            state_d     = S_TERM;
            last_seen_d = i_last;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_TERM: begin
        if (!leaf_full) begin
          write_d[leaf_q] = 1'b1;
          item_d          = '0;
          count_d         = '0;
          leaf_d          = leaf_nxt;
          state_d         = last_seen_q ? S_FLUSH : S_FILL;
        end
      end
      S_FLUSH: begin
        // Back at leaf 0 means every leaf now holds the same number of terminators.
        if (leaf_q == '0) begin
          state_d = S_DONE;
        end else if (!leaf_full) begin
          write_d[leaf_q] = 1'b1;
          item_d          = '0;
          leaf_d          = leaf_nxt;
        end
      end
      default: begin
        last_seen_d = 1'b0;
        leaf_d      = '0;
        count_d     = '0;
        state_d     = S_FILL;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_FILL;
      leaf_q      <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
      write_q     <= '0;
      item_q      <= '0;
    end else begin
      state_q     <= state_d;
      leaf_q      <= leaf_d;
      count_q     <= count_d;
      last_seen_q <= last_seen_d;
      write_q     <= write_d;
      item_q      <= item_d;
    end
  end

  assign o_fifo_write = write_q;
  assign o_fifo_item  = item_q;
  assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_leaf_run_distributor.sv
// Directed bench for leaf_run_distributor: write log per leaf checked against hand-built expectations.
module tb_leaf_run_distributor;

  logic        clk;
  logic        i_rst;
  logic [31:0] i_data;
  logic        i_valid;
  logic        i_last;
  logic        o_ready;
  logic [15:0] i_fifo_full;
  logic [31:0] o_fifo_item;
  logic [15:0] o_fifo_write;
  logic        o_done;
`ifdef LEAF_DIST_ZERO_GUARD_EN
  logic        o_zero_seen;
`endif

  leaf_run_distributor #(
    .N_LEAVES(16),
    .DATA_W  (32),
    .RUN_LEN (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .i_fifo_full (i_fifo_full),
    .o_fifo_item (o_fifo_item),
    .o_fifo_write(o_fifo_write),
    .o_done      (o_done)
`ifdef LEAF_DIST_ZERO_GUARD_EN
    ,
    .o_zero_seen (o_zero_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  logic [39:0] wlog[$];
  logic [39:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write log: one {leaf, item} entry per strobe cycle.
  always @(negedge clk) begin
    if (o_fifo_write != '0) begin
      int idx;
      idx = 0;
      check("onehot", 64'($countones(o_fifo_write)), 64'd1);
      for (int i = 0; i < 16; i++) if (o_fifo_write[i]) idx = i;
      wlog.push_back({idx[7:0], o_fifo_item});
    end
    if (o_done) done_cnt++;
  end

  task automatic expw(input int leaf, input logic [31:0] item);
    logic [7:0] l8;
    l8 = leaf[7:0];
    exp_q.push_back({l8, item});
  endtask

  task automatic clear_sb();
    wlog.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_data = '0; i_fifo_full = '0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    i_valid = 1'b1; i_data = d; i_last = l;
    #1;
    while (!o_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) check("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    check("done_cnt", 64'(done_cnt), 64'(target));
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_len"}, 64'(wlog.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      check(tag, 64'(wlog[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned snap;
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_data = '0; i_fifo_full = '0;
    #1;
    check("rst_write", 64'(o_fifo_write), 64'd0);
    check("rst_item", 64'(o_fifo_item), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;

    // Basic distribution: 1..64, one full run per leaf.
    clear_sb();
    for (int k = 0; k < 16; k++) begin
      for (int j = 1; j <= 4; j++) expw(k, 32'(4 * k + j));
      expw(k, 32'd0);
    end
    for (int i = 1; i <= 64; i++) send(32'(i), i == 64);
    wait_done(1);
    compare_log("basic");

    // Short pass: 1..6, flush terminators on leaves 2..15.
    do_reset();
    clear_sb();
    for (int j = 1; j <= 4; j++) expw(0, 32'(j));
    expw(0, 0); expw(1, 5); expw(1, 6); expw(1, 0);
    for (int k = 2; k < 16; k++) expw(k, 0);
    for (int i = 1; i <= 6; i++) send(32'(i), i == 6);
    wait_done(1);
    compare_log("short");

    // Backpressure mid-run and during the terminator.
    do_reset();
    clear_sb();
    for (int j = 1; j <= 4; j++) expw(0, 32'(j));
    expw(0, 0); expw(1, 5); expw(1, 0);
    for (int k = 2; k < 16; k++) expw(k, 0);
    i_fifo_full = 16'h00FE;
    #1;
    check("nonsel_ignored", 64'(o_ready), 64'd1);
    send(1, 0);
    send(2, 0);
    i_fifo_full = 16'h0001; i_valid = 1'b1; i_data = 3; i_last = 1'b0;
    #1;
    snap = wlog.size();
    for (int c = 0; c < 5; c++) begin
      check("bp_ready", 64'(o_ready), 64'd0);
      @(negedge clk); #1;
    end
    check("bp_nowrite", 64'(wlog.size()), 64'(snap));
    i_fifo_full = '0;
    send(3, 0);
    send(4, 0);
    i_fifo_full = 16'h0001;
    #1;
    snap = wlog.size();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
    end
    check("term_stall", 64'(wlog.size()), 64'(snap));
    i_fifo_full = '0;
    send(5, 1);
    wait_done(1);
    compare_log("bp");

    // Wrap boundary: two passes of 32.
    do_reset();
    clear_sb();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 8; k++) begin
        for (int j = 1; j <= 4; j++) expw(k, 32'(32 * p + 4 * k + j));
        expw(k, 0);
      end
      for (int k = 8; k < 16; k++) expw(k, 0);
    end
    for (int i = 1; i <= 32; i++) send(32'(i), i == 32);
    wait_done(1);
    for (int i = 33; i <= 64; i++) send(32'(i), i == 64);
    wait_done(2);
    compare_log("wrap");

    // Reset mid-run on leaf3, then a fresh pass from leaf0 with count restarted.
    do_reset();
    clear_sb();
    for (int i = 1; i <= 14; i++) send(32'(i), 1'b0);
    #1;
    check("pre_rst_write", 64'(o_fifo_write), 64'h0008);
    i_rst = 1'b1;
    #1;
    check("rst_async_write", 64'(o_fifo_write), 64'd0);
    check("rst_async_done", 64'(o_done), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("rst_hold_done", 64'(o_done), 64'd0);
    end
    i_rst = 1'b0;
    clear_sb();
    for (int j = 0; j < 4; j++) expw(0, 32'(100 + j));
    expw(0, 0); expw(1, 104); expw(1, 0);
    for (int k = 2; k < 16; k++) expw(k, 0);
    for (int i = 100; i <= 104; i++) send(32'(i), i == 104);
    wait_done(1);
    compare_log("post_rst");

    // Zero item handling.
    do_reset();
    clear_sb();
`ifdef LEAF_DIST_ZERO_GUARD_EN
    expw(0, 5); expw(0, 1); expw(0, 7); expw(0, 8); expw(0, 0);
`else
    expw(0, 5); expw(0, 0); expw(0, 7); expw(0, 8); expw(0, 0);
`endif
    for (int k = 1; k < 16; k++) expw(k, 0);
    send(5, 0);
`ifdef LEAF_DIST_ZERO_GUARD_EN
    #1;
    check("zero_seen_pre", 64'(o_zero_seen), 64'd0);
`endif
    send(0, 0);
`ifdef LEAF_DIST_ZERO_GUARD_EN
    #1;
    check("zero_seen_rise", 64'(o_zero_seen), 64'd1);
`endif
    send(7, 0);
    send(8, 1);
    wait_done(1);
`ifdef LEAF_DIST_ZERO_GUARD_EN
    check("zero_seen_sticky", 64'(o_zero_seen), 64'd1);
`endif
    compare_log("zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
